// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [21:0] NOP_WORD    = 22'b0;
  localparam int          WORD_OFFSET = 2;

  // Byte address to word index; callers truncate to their index width.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> WORD_OFFSET;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, registered read, no reset on contents.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 22,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
    if (re_i) rd_data_q <= mem_q[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder with fixed-latency valid/ready reads and a load port.
// Optional build macro IMEM_PARITY_EN adds a stored even-parity bit checked on every read.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 22,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              rsp_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef IMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  // Misaligned or beyond the last word of the array.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[WORD_OFFSET-1:0] != '0) || ((a >> (IDX_W + WORD_OFFSET)) != '0);
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              err_q, err_d;
  logic              req_ready_c, load_ready_c, accept, load_fire;
  logic [IDX_W-1:0]  req_idx, load_idx;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic [DATA_W-1:0] rd_data_raw;
  logic              par_err;

  assign req_idx  = IDX_W'(word_index(32'(req_addr)));
  assign load_idx = IDX_W'(word_index(32'(load_addr)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_c  = 1'b0;
    load_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A pending load only blocks requests when no request is presented.
        req_ready_c  = ~flush & ~(load_en & ~req_valid);
        load_ready_c = ~req_valid;
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        req_ready_c = rsp_ready & ~flush;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      req_ready_c  = 1'b0;
      load_ready_c = 1'b0;
    end
    accept = req_valid & req_ready_c;
    if (accept) begin
      cnt_d   = CNT_W'(LATENCY - 1);
      state_d = (LATENCY == 1) ? RESP : BUSY;
    end
    if (flush) state_d = IDLE;
  end

  assign rsp_addr_d = accept ? req_addr : rsp_addr_q;
  assign err_d      = accept ? addr_bad(req_addr) : err_q;
  assign load_fire  = load_en & load_ready_c & ~addr_bad(load_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_addr_q <= rsp_addr_d;
      err_q      <= err_d;
    end
  end

`ifdef IMEM_PARITY_EN
  assign wr_word     = {^load_data, load_data};
  assign rd_data_raw = rd_word[DATA_W-1:0];
  assign par_err     = ^rd_word;
`else
  assign wr_word     = load_data;
  assign rd_data_raw = rd_word;
  assign par_err     = 1'b0;
`endif

  // The array is read at the accept edge; no load can land before the response.
  imem_array #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i     (clk),
    .we_i      (load_fire),
    .wr_idx_i  (load_idx),
    .wr_data_i (wr_word),
    .re_i      (accept),
    .rd_idx_i  (req_idx),
    .rd_data_o (rd_word)
  );

  assign req_ready  = req_ready_c;
  assign load_ready = load_ready_c;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = (rsp_valid && !err_q) ? rd_data_raw : DATA_W'(NOP_WORD);
  assign rsp_addr   = rsp_addr_q;
  assign rsp_err    = rsp_valid & (err_q | par_err);

endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench for imem_responder (LATENCY=2, DEPTH=256).
module tb_imem_responder;

  localparam int LATENCY = 2;

  typedef struct {
    logic [21:0] addr;
    logic [21:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, flush, rsp_valid, rsp_err, rsp_ready;
  logic        load_en, load_ready;
  logic [21:0] req_addr, rsp_data, rsp_addr, load_addr, load_data;

  logic [21:0] mem_m [256];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  imem_responder #(
    .ADDR_W (22), .DATA_W (22), .DEPTH (256), .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [21:0] a);
    exp_t e;
    e.addr = a;
    e.err  = (a[1:0] != 2'b00) || (a >= 22'h400);
    e.data = e.err ? 22'h0 : mem_m[a[9:2]];
    return e;
  endfunction

  task automatic load(input logic [21:0] a, input logic [21:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    #1;
    check("load_ready", {31'b0, load_ready}, 32'd1);
    tick();
    load_en = 1'b0;
    if (a[1:0] == 2'b00 && a < 22'h400) mem_m[a[9:2]] = d;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic request(input exp_t e);
    int n;
    req_valid = 1'b1; req_addr = e.addr;
    #1;
    check("req_ready", {31'b0, req_ready}, 32'd1);
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    check("latency", n, LATENCY);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rsp_data",  {10'b0, rsp_data}, {10'b0, e.data});
    check("rsp_addr",  {10'b0, rsp_addr}, {10'b0, e.addr});
    check("rsp_err",   {31'b0, rsp_err},  {31'b0, e.err});
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    #1;
    compare_front();
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    foreach (mem_m[i]) mem_m[i] = '0;
    #3;
    check("rst_req_ready",  {31'b0, req_ready},  32'd0);
    check("rst_load_ready", {31'b0, load_ready}, 32'd0);
    check("rst_rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("rst_rsp_data",   {10'b0, rsp_data},   32'd0);
    check("rst_rsp_addr",   {10'b0, rsp_addr},   32'd0);
    check("rst_rsp_err",    {31'b0, rsp_err},    32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Program image, including a dropped out-of-range and a dropped misaligned load.
    load(22'h008, 22'h00ABCD);
    load(22'h00C, 22'h012345);
    load(22'h010, 22'h000111);
    load(22'h020, 22'h02A2A2);
    load(22'h000, 22'h3FFFFF);
    load(22'h034, 22'h005050);
    load(22'h3FC, 22'h155555);
    load(22'h408, 22'h03FFF0);
    load(22'h022, 22'h012121);

    // Basic read, latency, and hold while fetch stalls.
    request(mk(22'h008));
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_data",  {10'b0, rsp_data},  32'h00ABCD);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      tick();
    end
    // Handshake and new request in the same cycle.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 22'h00C;
    #1;
    check("b2b_req_ready", {31'b0, req_ready}, 32'd1);
    compare_front();
    sb.push_back(mk(22'h00C));
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    wait_rsp(n);
    check("b2b_latency", n, LATENCY);
    consume();

    // Error requests and the last valid word.
    request(mk(22'h006)); consume();
    request(mk(22'h400)); consume();
    request(mk(22'h3FC)); consume();
    request(mk(22'h020)); consume();

    // Flush one cycle after accepting 0x10, with 0x20 presented during the flush.
    req_valid = 1'b1; req_addr = 22'h010;
    tick();
    flush = 1'b1; req_addr = 22'h020;
    #1;
    check("flush_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    check("flush_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    request(mk(22'h020)); consume();

    // Flush while a response is pending drops rsp_valid next cycle.
    request(mk(22'h000));
    compare_front();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_resp_valid", {31'b0, rsp_valid}, 32'd0);

    // Load and request together: the request wins, the load waits for IDLE.
    load_en = 1'b1; load_addr = 22'h034; load_data = 22'h02AAAA;
    req_valid = 1'b1; req_addr = 22'h008;
    #1;
    check("conflict_load_ready", {31'b0, load_ready}, 32'd0);
    check("conflict_req_ready",  {31'b0, req_ready},  32'd1);
    sb.push_back(mk(22'h008));
    tick();
    req_valid = 1'b0;
    check("busy_load_ready", {31'b0, load_ready}, 32'd0);
    wait_rsp(n);
    check("conflict_latency", n, LATENCY);
    consume();
    load(22'h030, 22'h03C3C3);
    request(mk(22'h030)); consume();
    request(mk(22'h034)); consume();

    // Asynchronous reset in BUSY; contents must survive.
    req_valid = 1'b1; req_addr = 22'h020;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("arst_rsp_addr",   {10'b0, rsp_addr},   32'd0);
    check("arst_req_ready",  {31'b0, req_ready},  32'd0);
    check("arst_load_ready", {31'b0, load_ready}, 32'd0);
    tick();
    rst = 1'b1;
    request(mk(22'h008)); consume();

`ifdef IMEM_PARITY_EN
    dut.u_array.mem_q[2] = dut.u_array.mem_q[2] ^ 23'h1;
    e.addr = 22'h008; e.data = 22'h00ABCC; e.err = 1'b1;
    request(e); consume();
`else
    e = mk(22'h00C);
    request(e); consume();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
